// File: rtl/attr_pixel_pkg.sv
// Shared attribute field positions, palette geometry and reset palette contents
// for the text-mode attribute pixel pipeline.
package attr_pixel_pkg;

    localparam int unsigned ATT_BLINK   = 7;
    localparam int unsigned ATT_BG_LSB  = 4;
    localparam int unsigned ATT_INTENS  = 3;
    localparam int unsigned ATT_FG_LSB  = 0;

    localparam int unsigned PAL_ENTRIES = 16;
    localparam int unsigned PAL_AW      = 4;
    localparam int unsigned MAX_CW      = 16;

    typedef logic [3*MAX_CW-1:0] pal_word_t;

    // Channel c of entry {i,r,g,b}: MSB = c, next = i, remaining bits = c & i.
    // Result is packed {r,g,b} in the low 3*cw bits.
    function automatic pal_word_t default_entry(input logic [PAL_AW-1:0] idx,
                                                input int unsigned cw);
        pal_word_t e;
        logic      c;
        logic      i;
        e = '0;
        i = idx[3];
        for (int unsigned ch = 0; ch < 3; ch++) begin
            c = idx[ch];
            for (int unsigned k = 0; k < cw; k++) begin
                if (k == cw - 1)
                    e[ch*cw + k] = c;
                else if (k == cw - 2)
                    e[ch*cw + k] = i;
                else
                    e[ch*cw + k] = c & i;
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/attr_pixel_pipe_if.sv
// Palette write port between the host and the pixel pipeline; the host drives
// the request and receives a one-clock acknowledge.
interface attr_pixel_pipe_if
    import attr_pixel_pkg::*;
#(
    parameter int unsigned CW = 3
);
    logic              pal_wr;
    logic [PAL_AW-1:0] pal_addr;
    logic [3*CW-1:0]   pal_data;
    logic              pal_ack;

    modport master (output pal_wr, pal_addr, pal_data, input pal_ack);
    modport slave  (input pal_wr, pal_addr, pal_data, output pal_ack);
endinterface

// File: rtl/attr_palette.sv
// 16-entry colour palette: async reset to default colours, one write port
// taking every clk, one pixclk-enabled registered read port (read-before-write).
module attr_palette
    import attr_pixel_pkg::*;
#(
    parameter int unsigned CW = 3
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [PAL_AW-1:0] wr_addr,
    input  logic [3*CW-1:0]   wr_data,
    input  logic              rd_en,
    input  logic              rd_pass,
    input  logic [PAL_AW-1:0] rd_addr,
    output logic [3*CW-1:0]   rd_data
);
    localparam int unsigned EW = 3*CW;

    logic [EW-1:0] mem_q [PAL_ENTRIES];
    logic [EW-1:0] mem_d [PAL_ENTRIES];
    logic [EW-1:0] rd_q;
    logic [EW-1:0] rd_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en)
            mem_d[wr_addr] = wr_data;
    end

    // Reads sample mem_q, so a same-clk write to the read entry is seen next time.
    always_comb begin
        rd_d = rd_q;
        if (rd_en)
            rd_d = rd_pass ? mem_q[rd_addr] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PAL_ENTRIES; i++)
                mem_q[i] <= EW'(default_entry(PAL_AW'(i), CW));
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/attr_pixel_pipe.sv
// Text-mode pixel output stage: attribute + glyph bit -> palette index -> RGB,
// with frame-driven blink, blinking cursor overlay and sync delay matching.
module attr_pixel_pipe
    import attr_pixel_pkg::*;
#(
    parameter int unsigned CW           = 3,
    parameter int unsigned BLINK_FRAMES = 16
)
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pixclk,
    input  logic [7:0]          attcode,
    input  logic                pixel,
    input  logic                cursor,
    input  logic                blank,
    input  logic                hsync_in,
    input  logic                vsync_in,
    attr_pixel_pipe_if.slave    pal,
    output logic                blink_phase,
    output logic [CW-1:0]       r,
    output logic [CW-1:0]       g,
    output logic [CW-1:0]       b,
    output logic                hsync,
    output logic                vsync
);
    localparam int unsigned    FCW     = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

    logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
    logic              blink_q, blink_d;
    logic [PAL_AW-1:0] idx_q, idx_d;
    logic              blank_q, blank_d;
    logic              hs1_q, hs1_d, vs1_q, vs1_d;
    logic              hs2_q, hs2_d, vs2_q, vs2_d;
    logic              ack_q, ack_d;

    logic              vs_edge;
    logic              fg, cur, eff;
    logic [3*CW-1:0]   rgb;

    // vs1_q is the previous pixclk-sampled vsync_in, so it doubles as edge history.
    always_comb begin
        vs_edge     = pixclk & vsync_in & ~vs1_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (vs_edge) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        fg      = pixel & ~(attcode[ATT_BLINK] & blink_q);
        cur     = cursor & ~blink_q;
        eff     = fg ^ cur;
        idx_d   = idx_q;
        blank_d = blank_q;
        hs1_d   = hs1_q;
        vs1_d   = vs1_q;
        hs2_d   = hs2_q;
        vs2_d   = vs2_q;
        if (pixclk) begin
            idx_d   = eff ? attcode[ATT_INTENS:ATT_FG_LSB]
                          : {1'b0, attcode[ATT_BG_LSB+2:ATT_BG_LSB]};
            blank_d = blank;
            hs1_d   = hsync_in;
            vs1_d   = vsync_in;
            hs2_d   = hs1_q;
            vs2_d   = vs1_q;
        end
        ack_d = pal.pal_wr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
            idx_q       <= '0;
            blank_q     <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            idx_q       <= idx_d;
            blank_q     <= blank_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            hs2_q       <= hs2_d;
            vs2_q       <= vs2_d;
            ack_q       <= ack_d;
        end
    end

    // Stage 2 colour register lives in the palette read port, blank applied there.
    attr_palette #(.CW(CW)) u_palette (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (pal.pal_wr),
        .wr_addr (pal.pal_addr),
        .wr_data (pal.pal_data),
        .rd_en   (pixclk),
        .rd_pass (blank_q),
        .rd_addr (idx_q),
        .rd_data (rgb)
    );

    assign {r, g, b}   = rgb;
    assign hsync       = hs2_q;
    assign vsync       = vs2_q;
    assign blink_phase = blink_q;
    assign pal.pal_ack = ack_q;

endmodule

// File: doc/attr_pixel_pipe.md
# attr_pixel_pipe

Parametrised successor to the text-mode pixel output stage. Converts a character-cell pixel bit and 8-bit attribute code into RGB through a programmable 16-entry palette. Generates the blink phase internally from frame count and overlays a blinking cursor. Sits between the character generator and the DAC/VGA pins. Sync signals are delayed to stay aligned with colour.

## Interface
- CW, 3: bits per colour channel (CW ≥ 2)
- BLINK_FRAMES, 16: frames per blink half-period (≥ 2)
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pixclk  in  1  pixel enable; pipeline advances only on cycles with pixclk=1
- attcode  in  8  attribute: [7] blink, [6:4] bg RGB, [3] intensify, [2:0] fg RGB
- pixel  in  1  glyph pixel (1 = foreground)
- cursor  in  1  pixel lies inside the cursor shape
- blank  in  1  display enable (1 = visible, 0 = force black)
- hsync_in, vsync_in  in  1 each  raw syncs, aligned with pixel
- pal_wr  in  1  palette write request (single-cycle pulse)
- pal_addr  in  4  palette index to write
- pal_data  in  3*CW  {r,g,b} entry value
- pal_ack  out  1  write done, one clk after pal_wr
- blink_phase  out  1  current blink phase (1 = blinked-off half)
- r, g, b  out  CW each  colour outputs
- hsync, vsync  out  1 each  delayed syncs

## Operation
- Blink generator: on a pixclk cycle, detect a vsync_in 0→1 transition against its previous sampled value. Each detected edge increments frame_cnt (width clog2(BLINK_FRAMES)). When frame_cnt == BLINK_FRAMES-1, it wraps to 0 and blink_phase toggles.
- Stage 1, on pixclk:
  - fg = pixel & ~(attcode[7] & blink_phase)
  - cur = cursor & ~blink_phase
  - eff = fg ^ cur
  - idx = eff ? {attcode[3], attcode[2:0]} : {1'b0, attcode[6:4]}
  - Register idx, blank, hsync_in and vsync_in.
- Stage 2, on pixclk: read palette[idx_q]; {r,g,b} <= blank_q ? entry : 0. Syncs shift through.
- Palette reset contents for index {i,c_r,c_g,c_b}, per channel c:
  - bit CW-1 = c
  - bit CW-2 = i
  - bits CW-3..0 = c&i replicated
  - For CW=3 this gives {c, i, c&i}.
- Palette writes are independent of pixclk and are accepted every clk.
- pal_ack is a registered copy of pal_wr.
- When the stage-2 read and a write hit the same entry in the same clk, the read returns the old value (read-before-write).

## Timing
- Reset values:
  - r, g, b = 0; hsync = vsync = 0; pal_ack = 0
  - blink_phase = 0; frame_cnt = 0
  - pipeline registers = 0; palette = default contents
- Latency: inputs reach r/g/b/hsync/vsync exactly 2 pixclk-enabled cycles later; syncs and colour stay aligned.
- With pixclk=0, every register except the palette and pal_ack holds.
- A vsync_in edge on a non-pixclk cycle is not counted until it is sampled on a pixclk cycle.
- blink_phase changes on the pixclk cycle that samples the BLINK_FRAMES-th edge, and applies to stage 1 on the next pixclk cycle.
- Reset mid-frame: all state clears asynchronously. Outputs stay black until two pixclk cycles after reset_n deasserts. Palette writes made before reset are lost.
- pal_wr during reset is ignored and produces no ack.

## Structure
- Package attr_pixel_pkg holds:
  - attribute field index constants
  - PAL_ENTRIES = 16
  - function default_entry(idx, CW) returning the reset palette value
- Sub-module attr_palette: 16×3CW register file with async reset to defaults, one write port and one synchronous pixclk-enabled read port with read-before-write.

## Test plan
- Defaults, CW=3: attcode=0x1E, pixel=1, blank=1 → r=7, g=7, b=2 after 2 pixclk; pixel=0 → r=0, g=0, b=4.
- Blank and latency: blank=0 with any attcode → rgb=0. hsync_in pulse appears on hsync exactly 2 pixclk later. pixclk held at 0 for 5 clk → outputs frozen.
- Blink, BLINK_FRAMES=2: two vsync rising edges → blink_phase=1. attcode=0x8F, pixel=1 → output switches from entry 0xF (7,7,7) to entry 0 (0,0,0).
- Cursor: cursor=1, pixel=0, attcode=0x07, blink_phase=0 → entry 0x7 colour. When blink_phase=1 → entry 0 colour.
- Palette write: pal_wr with addr=5, data=0x1FF → pal_ack one clk later; later index-5 pixels output (7,7,7). A same-clk read of entry 5 returns the old value.
- Reset mid-operation: assert reset_n=0 during active video → r/g/b/syncs/blink_phase go 0 immediately and the palette returns to defaults.
